// File: rtl/motor_wdt_pkg.sv
// rtl/motor_wdt_pkg.sv - shared state encoding and default timing for the motor watchdog
package motor_wdt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_BITE  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int DEF_TIMEOUT  = 1024;
    localparam int DEF_BITE_LEN = 32;
    localparam int DEF_HOLDOFF  = 64;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_FAULT_W  = 8;
    localparam int DEF_WIN_MIN  = 16;

endpackage

// File: rtl/wdt_sat_counter.sv
// rtl/wdt_sat_counter.sv - saturating event counter, sync clear applied before increment
module wdt_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            // a clear that coincides with an event still records that event
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/motor_watchdog.sv
// rtl/motor_watchdog.sv - heartbeat watchdog issuing a fixed-length reset request on timeout
// Optional window check (early kicks bite) enabled by defining MOTOR_WATCHDOG_WINDOW_EN.
module motor_watchdog
    import motor_wdt_pkg::*;
#(
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int BITE_LEN = DEF_BITE_LEN,
    parameter int HOLDOFF  = DEF_HOLDOFF,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FAULT_W  = DEF_FAULT_W
`ifdef MOTOR_WATCHDOG_WINDOW_EN
    ,
    parameter int WIN_MIN  = DEF_WIN_MIN
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               kick,
    input  logic               clear_fault,
    output logic               wdt_rst,
    output logic               fault,
    output logic [FAULT_W-1:0] fault_cnt,
    output logic [1:0]         wd_state
);

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BITE_LAST = CNT_W'(BITE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             bite_go;
    logic             early_kick;

`ifdef MOTOR_WATCHDOG_WINDOW_EN
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_MIN - 1);
    assign early_kick = kick && (timer < WIN_LAST);
`else
    assign early_kick = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bite_go   = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (enable) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end else if (early_kick) begin
                    bite_go = 1'b1;
                end else if (kick) begin
                    // a kick on the expiry cycle still rescues the system
                    timer_nxt = '0;
                end else if (timer == TO_LAST) begin
                    bite_go = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
                if (bite_go) begin
                    state_nxt = ST_BITE;
                    timer_nxt = '0;
                end
            end
            ST_BITE: begin
                if (timer == BITE_LAST) begin
                    state_nxt = ST_HOLD;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_nxt = enable ? ST_ARMED : ST_IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            wdt_rst <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            wdt_rst <= (state_nxt == ST_BITE);
            if (bite_go) begin
                fault <= 1'b1;
            end else if (clear_fault) begin
                fault <= 1'b0;
            end
        end
    end

    wdt_sat_counter #(
        .W (FAULT_W)
    ) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_fault),
        .inc   (bite_go),
        .count (fault_cnt)
    );

    assign wd_state = state;

endmodule

// File: tb/tb_motor_watchdog.sv
// tb/tb_motor_watchdog.sv - directed self-checking bench for motor_watchdog
module tb_motor_watchdog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       kick = 1'b0;
    logic       clear_fault = 1'b0;
    logic       wdt_rst;
    logic       fault;
    logic [7:0] fault_cnt;
    logic [1:0] wd_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    motor_watchdog #(
        .TIMEOUT  (10),
        .BITE_LEN (4),
        .HOLDOFF  (3),
        .CNT_W    (16),
        .FAULT_W  (8)
`ifdef MOTOR_WATCHDOG_WINDOW_EN
        ,
        .WIN_MIN  (3)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .kick        (kick),
        .clear_fault (clear_fault),
        .wdt_rst     (wdt_rst),
        .fault       (fault),
        .fault_cnt   (fault_cnt),
        .wd_state    (wd_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sr(input string tag, input logic [1:0] st, input logic wr);
        chk({tag, "_state"}, 32'(wd_state), 32'(st));
        chk({tag, "_wdt_rst"}, 32'(wdt_rst), 32'(wr));
    endtask

    // Called right after ARMED entry with no kicks pending; ends right after re-entry to ARMED.
    task automatic run_bite(input string tag, input int exp_cnt);
        for (int i = 1; i <= 9; i++) begin
            tick();
            expect_sr({tag, "_armed"}, 2'd1, 1'b0);
        end
        tick();
        expect_sr({tag, "_entry"}, 2'd2, 1'b1);
        chk({tag, "_fault"}, 32'(fault), 32'd1);
        chk({tag, "_cnt"}, 32'(fault_cnt), 32'(exp_cnt));
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sr({tag, "_bite"}, 2'd2, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sr({tag, "_hold"}, 2'd3, 1'b0);
        end
        tick();
        expect_sr({tag, "_rearm"}, 2'd1, 1'b0);
    endtask

    initial begin
        // reset, then idle with enable low
        tick();
        tick();
        rst = 1'b0;
        expect_sr("rst", 2'd0, 1'b0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cnt", 32'(fault_cnt), 32'd0);
        for (int i = 0; i < 50; i++) begin
            tick();
            expect_sr("idle", 2'd0, 1'b0);
        end
        chk("idle_fault", 32'(fault), 32'd0);

        // regular kicks every 8 clocks
        enable = 1'b1;
        tick();
        expect_sr("arm", 2'd1, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            kick = (i % 8 == 0);
            tick();
            expect_sr("kicked", 2'd1, 1'b0);
        end
        kick = 1'b0;
        chk("kicked_cnt", 32'(fault_cnt), 32'd0);
        chk("kicked_fault", 32'(fault), 32'd0);

        // clean ARMED entry, then two timeouts
        enable = 1'b0;
        tick();
        expect_sr("disarm", 2'd0, 1'b0);
        enable = 1'b1;
        tick();
        expect_sr("rearm", 2'd1, 1'b0);
        run_bite("to1", 1);
        run_bite("to2", 2);

        // kick on the expiry cycle rescues
        for (int i = 0; i < 9; i++) tick();
        kick = 1'b1;
        tick();
        kick = 1'b0;
        expect_sr("edge_kick", 2'd1, 1'b0);
        chk("edge_kick_cnt", 32'(fault_cnt), 32'd2);

        // clear_fault colliding with bite entry
        for (int i = 0; i < 9; i++) tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        expect_sr("clr_bite", 2'd2, 1'b1);
        chk("clr_bite_fault", 32'(fault), 32'd1);
        chk("clr_bite_cnt", 32'(fault_cnt), 32'd1);

        // reset on the second bite cycle
        tick();
        expect_sr("bite2", 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_sr("mid_rst", 2'd0, 1'b0);
        chk("mid_rst_cnt", 32'(fault_cnt), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);

        // kick one clock after ARMED entry
        tick();
        expect_sr("win_arm", 2'd1, 1'b0);
        kick = 1'b1;
        tick();
        kick = 1'b0;
`ifdef MOTOR_WATCHDOG_WINDOW_EN
        expect_sr("early_kick", 2'd2, 1'b1);
        chk("early_kick_cnt", 32'(fault_cnt), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        tick();
        expect_sr("win_rearm", 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        kick = 1'b1;
        tick();
        kick = 1'b0;
        expect_sr("late_kick", 2'd1, 1'b0);
        chk("late_kick_cnt", 32'(fault_cnt), 32'd1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_cnt", 32'(fault_cnt), 32'd0);
        chk("clear_fault", 32'(fault), 32'd0);
`else
        expect_sr("early_kick", 2'd1, 1'b0);
        chk("early_kick_cnt", 32'(fault_cnt), 32'd0);
`endif

        // disable from ARMED
        enable = 1'b0;
        tick();
        expect_sr("final_idle", 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
